// File: rtl/window_scan_ctrl_if.sv
// Handshake/bus bundle between the window scan sequencer and its
// neighbours (pixel source, window memory, downstream filter).
//   master : drives start, pix_valid, pix_data, out_ready; observes the rest
//   slave  : the sequencer side (window_scan_ctrl)
interface window_scan_ctrl_if;
   logic       start;
   logic       pix_valid;
   logic [7:0] pix_data;
   logic       pix_ready;
   logic       out_ready;
   logic       mem_rst_n;
   logic       mem_wr;
   logic [7:0] mem_pixelw;
   logic       mem_rd;
   logic       win_valid;
   logic [5:0] win_row;
   logic [7:0] win_col;
   logic       busy;
   logic       done;

   modport master (
      output start, pix_valid, pix_data, out_ready,
      input  pix_ready, mem_rst_n, mem_wr, mem_pixelw, mem_rd,
             win_valid, win_row, win_col, busy, done
   );

   modport slave (
      input  start, pix_valid, pix_data, out_ready,
      output pix_ready, mem_rst_n, mem_wr, mem_pixelw, mem_rd,
             win_valid, win_row, win_col, busy, done
   );
endinterface

// File: rtl/window_scan_ctrl.sv
// Sequencer for the padded 3x3 window memory. Per frame it pulses the
// memory reset to rewind its pointers, streams LOAD_WORDS pixels in, then
// issues one read per output window (IMG_W x OUT_ROWS) and tags each window
// with row/col, aligned RD_LAT cycles after the read.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   ctl  : window_scan_ctrl_if.slave (start, pixel handshake, memory
//          control, window valid/tags, busy/done status)
module window_scan_ctrl #(
   parameter int unsigned IMG_W      = 256,
   parameter int unsigned OUT_ROWS   = 32,
   parameter int unsigned LOAD_WORDS = 8772,
   parameter int unsigned RD_LAT     = 1
) (
   input logic                clk,
   input logic                rst,
   window_scan_ctrl_if.slave  ctl
);

   localparam logic [13:0] LOAD_LAST  = 14'(LOAD_WORDS - 1);
   localparam logic [13:0] ISSUE_TOT  = 14'(IMG_W * OUT_ROWS);
   localparam logic [13:0] ISSUE_LAST = 14'(IMG_W * OUT_ROWS - 1);
   localparam logic [7:0]  COL_LAST   = 8'(IMG_W - 1);
   localparam int unsigned DW         = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [DW-1:0] DRAIN_LAST = DW'(RD_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LOAD, S_SCAN, S_DRAIN, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [13:0]   load_cnt_q, load_cnt_d;
   logic [13:0]   issue_cnt_q, issue_cnt_d;
   logic [7:0]    col_q, col_d;
   logic [5:0]    row_q, row_d;
   logic [DW-1:0] drain_q, drain_d;
   logic          done_q, done_d;
   logic          accept, rd;

   logic          vld_q [RD_LAT];
   logic [5:0]    row_pipe_q [RD_LAT];
   logic [7:0]    col_pipe_q [RD_LAT];

   assign accept = (state_q == S_LOAD) && ctl.pix_valid;
   assign rd     = (state_q == S_SCAN) && ctl.out_ready && (issue_cnt_q < ISSUE_TOT);

   always_comb begin
      state_d     = state_q;
      load_cnt_d  = load_cnt_q;
      issue_cnt_d = issue_cnt_q;
      col_d       = col_q;
      row_d       = row_q;
      drain_d     = drain_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (ctl.start) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            load_cnt_d  = '0;
            issue_cnt_d = '0;
            col_d       = '0;
            row_d       = '0;
            drain_d     = '0;
            state_d     = S_LOAD;
         end
         S_LOAD: begin
            if (accept) begin
               load_cnt_d = load_cnt_q + 14'd1;
               if (load_cnt_q == LOAD_LAST) state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (rd) begin
               issue_cnt_d = issue_cnt_q + 14'd1;
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = row_q + 6'd1;
               end else begin
                  col_d = col_q + 8'd1;
               end
               if (issue_cnt_q == ISSUE_LAST) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Hold for RD_LAT cycles so the last window leaves the memory
            if (drain_q == DRAIN_LAST) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         load_cnt_q  <= '0;
         issue_cnt_q <= '0;
         col_q       <= '0;
         row_q       <= '0;
         drain_q     <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_cnt_q  <= load_cnt_d;
         issue_cnt_q <= issue_cnt_d;
         col_q       <= col_d;
         row_q       <= row_d;
         drain_q     <= drain_d;
         done_q      <= done_d;
      end
   end

   // Read strobe and issue tags delayed to line up with the memory outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            vld_q[i]      <= 1'b0;
            row_pipe_q[i] <= '0;
            col_pipe_q[i] <= '0;
         end
      end else begin
         vld_q[0]      <= rd;
         row_pipe_q[0] <= row_q;
         col_pipe_q[0] <= col_q;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            vld_q[i]      <= vld_q[i-1];
            row_pipe_q[i] <= row_pipe_q[i-1];
            col_pipe_q[i] <= col_pipe_q[i-1];
         end
      end
   end

   assign ctl.pix_ready  = (state_q == S_LOAD);
   assign ctl.mem_wr     = accept;
   assign ctl.mem_pixelw = accept ? ctl.pix_data : '0;
   assign ctl.mem_rd     = rd;
   assign ctl.mem_rst_n  = (state_q != S_CLEAR);
   assign ctl.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
   assign ctl.done       = done_q;
   assign ctl.win_valid  = vld_q[RD_LAT-1];
   assign ctl.win_row    = row_pipe_q[RD_LAT-1];
   assign ctl.win_col    = col_pipe_q[RD_LAT-1];

endmodule

// File: tb/tb_window_scan_ctrl.sv
module tb_window_scan_ctrl;
   localparam int unsigned IMG_W      = 8;
   localparam int unsigned OUT_ROWS   = 5;
   localparam int unsigned LOAD_WORDS = (IMG_W + 2) * (OUT_ROWS + 2);
   localparam int unsigned TOTAL      = IMG_W * OUT_ROWS;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   window_scan_ctrl_if ctl_if ();

   window_scan_ctrl #(
      .IMG_W(IMG_W), .OUT_ROWS(OUT_ROWS), .LOAD_WORDS(LOAD_WORDS), .RD_LAT(1)
   ) dut (
      .clk(clk), .rst(rst), .ctl(ctl_if)
   );

   int          checks = 0;
   int          errors = 0;
   int unsigned exp_q[$];
   int          wr_cnt = 0;
   int          win_cnt = 0;
   logic        prev_rd = 1'b0;
   logic        mon_en = 1'b0;

   // Scoreboard side: every window leaving the memory is popped and compared
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if (ctl_if.mem_wr === 1'b1 && ctl_if.mem_rd === 1'b1) begin
            errors++;
            $display("FAIL wr_rd_overlap: mem_wr=%b mem_rd=%b required not both 1", ctl_if.mem_wr, ctl_if.mem_rd);
         end
         checks++;
         if (ctl_if.win_valid !== prev_rd) begin
            errors++;
            $display("FAIL win_align: win_valid=%b required %b", ctl_if.win_valid, prev_rd);
         end
         if (ctl_if.win_valid === 1'b1) begin
            int unsigned got, e;
            win_cnt++;
            got = int'(ctl_if.win_row) * 256 + int'(ctl_if.win_col);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL win_tag: got row%0d col%0d, required no window", ctl_if.win_row, ctl_if.win_col);
            end else begin
               e = exp_q.pop_front();
               if (got != e) begin
                  errors++;
                  $display("FAIL win_tag: got row%0d col%0d, required row%0d col%0d",
                           got / 256, got % 256, e / 256, e % 256);
               end
            end
         end
         if (ctl_if.mem_wr === 1'b1) wr_cnt++;
         prev_rd = rst ? 1'b0 : ctl_if.mem_rd;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [28:0] obs;
      rst = 1'b1;
      ctl_if.start = 1'b0;
      ctl_if.pix_valid = 1'b0;
      ctl_if.pix_data = 8'h00;
      ctl_if.out_ready = 1'b0;
      repeat (3) tick;
      @(negedge clk);
      obs = {ctl_if.mem_rst_n, ctl_if.mem_wr, ctl_if.mem_rd, ctl_if.win_valid, ctl_if.done,
             ctl_if.busy, ctl_if.pix_ready, ctl_if.mem_pixelw, ctl_if.win_row, ctl_if.win_col};
      checks++;
      if (obs !== {1'b1, 6'b0, 8'h00, 6'd0, 8'd0}) begin
         errors++;
         $display("FAIL reset_outputs: got %h required %h", obs, {1'b1, 28'h0});
      end
      tick;
      rst = 1'b0;
      prev_rd = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic start_frame;
      tick;
      ctl_if.start = 1'b1;
      tick;
      ctl_if.start = 1'b0;
      @(negedge clk);
      checks++;
      if (ctl_if.mem_rst_n !== 1'b0 || ctl_if.busy !== 1'b1) begin
         errors++;
         $display("FAIL clear_pulse: mem_rst_n=%b busy=%b required 0/1", ctl_if.mem_rst_n, ctl_if.busy);
      end
      wr_cnt = 0;
      win_cnt = 0;
   endtask

   // gap!=0: pixel offered one cycle in three
   task automatic load_frame(input int gap, input int start_at);
      int k = 0;
      int cyc = 0;
      while (k < int'(LOAD_WORDS)) begin
         tick;
         ctl_if.pix_valid = (gap == 0) || (cyc % 3 == 0);
         ctl_if.pix_data  = ctl_if.pix_valid ? 8'(k % 256) : 8'hA5;
         ctl_if.start     = (cyc == start_at);
         @(negedge clk);
         checks++;
         if (ctl_if.pix_ready !== 1'b1 || ctl_if.mem_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL load_ready: pix_ready=%b mem_rst_n=%b required 1/1 (k=%0d)",
                     ctl_if.pix_ready, ctl_if.mem_rst_n, k);
         end
         checks++;
         if (ctl_if.mem_wr !== ctl_if.pix_valid) begin
            errors++;
            $display("FAIL load_wr: mem_wr=%b required %b (k=%0d)", ctl_if.mem_wr, ctl_if.pix_valid, k);
         end
         if (ctl_if.pix_valid) begin
            checks++;
            if (ctl_if.mem_pixelw !== 8'(k % 256)) begin
               errors++;
               $display("FAIL load_data: mem_pixelw=%h required %h", ctl_if.mem_pixelw, 8'(k % 256));
            end
            k++;
         end
         cyc++;
      end
      tick;
      ctl_if.pix_valid = 1'b0;
      ctl_if.start = 1'b0;
      ctl_if.out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (ctl_if.pix_ready !== 1'b0 || ctl_if.mem_rd !== 1'b0 || ctl_if.busy !== 1'b1) begin
         errors++;
         $display("FAIL scan_entry: pix_ready=%b mem_rd=%b busy=%b required 0/0/1",
                  ctl_if.pix_ready, ctl_if.mem_rd, ctl_if.busy);
      end
      checks++;
      if (wr_cnt != int'(LOAD_WORDS)) begin
         errors++;
         $display("FAIL wr_count: got %0d required %0d", wr_cnt, LOAD_WORDS);
      end
   endtask

   task automatic scan_frame(input int stall_after, input int stall_len,
                             input int start_at, input int abort_after);
      int m = 0;
      int cyc = 0;
      int stall = 0;
      while (m < int'(TOTAL) && cyc < int'(TOTAL) + 50) begin
         if (abort_after > 0 && m == abort_after) break;
         tick;
         ctl_if.out_ready = (stall == 0);
         ctl_if.start = (cyc == start_at);
         @(negedge clk);
         checks++;
         if (ctl_if.mem_rd !== ctl_if.out_ready) begin
            errors++;
            $display("FAIL scan_rd: mem_rd=%b required %b (issue %0d)", ctl_if.mem_rd, ctl_if.out_ready, m);
         end
         checks++;
         if (ctl_if.busy !== 1'b1 || ctl_if.pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL scan_status: busy=%b pix_ready=%b required 1/0", ctl_if.busy, ctl_if.pix_ready);
         end
         if (ctl_if.out_ready) begin
            exp_q.push_back(int'(m / IMG_W) * 256 + int'(m % IMG_W));
            if (m == stall_after) stall = stall_len;
            m++;
         end else if (stall > 0) begin
            stall--;
         end
         cyc++;
      end
      ctl_if.start = 1'b0;
      if (abort_after <= 0) begin
         checks++;
         if (m != int'(TOTAL)) begin
            errors++;
            $display("FAIL scan_timeout: issued %0d required %0d", m, TOTAL);
         end
      end
   endtask

   task automatic finish_frame;
      tick;
      @(negedge clk);
      checks++;
      if (ctl_if.mem_rd !== 1'b0 || ctl_if.busy !== 1'b1 || ctl_if.done !== 1'b0) begin
         errors++;
         $display("FAIL drain: mem_rd=%b busy=%b done=%b required 0/1/0", ctl_if.mem_rd, ctl_if.busy, ctl_if.done);
      end
      tick;
      @(negedge clk);
      checks++;
      if (ctl_if.done !== 1'b1 || ctl_if.busy !== 1'b0 || ctl_if.win_valid !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: done=%b busy=%b win_valid=%b required 1/0/0",
                  ctl_if.done, ctl_if.busy, ctl_if.win_valid);
      end
      tick;
      @(negedge clk);
      checks++;
      if (ctl_if.done !== 1'b0) begin
         errors++;
         $display("FAIL done_width: done=%b required 0", ctl_if.done);
      end
      checks++;
      if (win_cnt != int'(TOTAL) || exp_q.size() != 0) begin
         errors++;
         $display("FAIL win_count: got %0d windows (%0d pending) required %0d", win_cnt, exp_q.size(), TOTAL);
      end
   endtask

   task automatic test_ramp_frame;
      start_frame;
      load_frame(0, -1);
      scan_frame(-1, 0, -1, 0);
      finish_frame;
   endtask

   task automatic test_gapped_load;
      start_frame;
      load_frame(1, -1);
      scan_frame(-1, 0, -1, 0);
      finish_frame;
   endtask

   task automatic test_stall;
      start_frame;
      load_frame(0, -1);
      scan_frame(3 * int'(IMG_W) + int'(IMG_W) - 1, 5, -1, 0);
      finish_frame;
   endtask

   task automatic test_reset_mid_scan;
      logic [28:0] obs;
      start_frame;
      load_frame(0, -1);
      scan_frame(-1, 0, -1, 10);
      tick;
      rst = 1'b1;
      ctl_if.out_ready = 1'b0;
      tick;
      @(negedge clk);
      obs = {ctl_if.mem_rst_n, ctl_if.mem_wr, ctl_if.mem_rd, ctl_if.win_valid, ctl_if.done,
             ctl_if.busy, ctl_if.pix_ready, ctl_if.mem_pixelw, ctl_if.win_row, ctl_if.win_col};
      checks++;
      if (obs !== {1'b1, 6'b0, 8'h00, 6'd0, 8'd0} || exp_q.size() != 0) begin
         errors++;
         $display("FAIL mid_reset: got %h (%0d pending) required %h", obs, exp_q.size(), {1'b1, 28'h0});
      end
      tick;
      rst = 1'b0;
      start_frame;
      load_frame(0, -1);
      scan_frame(-1, 0, -1, 0);
      finish_frame;
   endtask

   task automatic test_start_ignored;
      start_frame;
      load_frame(0, 5);
      scan_frame(-1, 0, 3, 0);
      finish_frame;
   endtask

   initial begin
      test_reset;
      test_ramp_frame;
      test_gapped_load;
      test_stall;
      test_reset_mid_scan;
      test_start_ignored;
      test_ramp_frame;
      repeat (2) tick;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
